// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: opcodes, shift types, default width
// and the occupancy states of the operand register pipeline.
package alu_pkg;

    localparam int N_DEF = 32;

    localparam logic [3:0] OPC_AND = 4'd0;
    localparam logic [3:0] OPC_EOR = 4'd1;
    localparam logic [3:0] OPC_SUB = 4'd2;
    localparam logic [3:0] OPC_RSB = 4'd3;
    localparam logic [3:0] OPC_ADD = 4'd4;
    localparam logic [3:0] OPC_ADC = 4'd5;
    localparam logic [3:0] OPC_SBC = 4'd6;
    localparam logic [3:0] OPC_RSC = 4'd7;
    localparam logic [3:0] OPC_TST = 4'd8;
    localparam logic [3:0] OPC_TEQ = 4'd9;
    localparam logic [3:0] OPC_CMP = 4'd10;
    localparam logic [3:0] OPC_CMN = 4'd11;
    localparam logic [3:0] OPC_ORR = 4'd12;
    localparam logic [3:0] OPC_MOV = 4'd13;
    localparam logic [3:0] OPC_BIC = 4'd14;
    localparam logic [3:0] OPC_MVN = 4'd15;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // ST_SKID is only reachable when the skid buffer is built in.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OUT   = 2'd1,
        ST_SKID  = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus of the ALU operand stage. Both sides use valid/ready:
// a transfer happens in any cycle where valid and ready are both 1; valid never waits on ready.
interface alu_operand_stage_if #(parameter int N = 32);

    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_opc;
    logic [N-1:0] in_op1;
    logic [N-1:0] in_rm;
    logic         in_imm_sel;
    logic [7:0]   in_imm8;
    logic [3:0]   in_rot;
    logic [1:0]   in_sh_type;
    logic [7:0]   in_sh_amt;
    logic         c_flag;

    logic         out_valid;
    logic         out_ready;
    logic [3:0]   opc;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         c_shifter;

    modport slave (
        input  in_valid, in_opc, in_op1, in_rm, in_imm_sel, in_imm8, in_rot,
               in_sh_type, in_sh_amt, c_flag, out_ready,
        output in_ready, out_valid, opc, op1, op2, c_shifter
    );

    modport master (
        output in_valid, in_opc, in_op1, in_rm, in_imm_sel, in_imm8, in_rot,
               in_sh_type, in_sh_amt, c_flag, out_ready,
        input  in_ready, out_valid, opc, op1, op2, c_shifter
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational operand-2 generator: rotated immediate or shifted register,
// with the shifter carry-out. Written for N a power of two (N=32 in practice).
module barrel_shifter
    import alu_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] rm_i,
    input  logic [7:0]   amt_i,
    input  logic [1:0]   sh_type_i,
    input  logic         c_i,
    input  logic         imm_sel_i,
    input  logic [7:0]   imm8_i,
    input  logic [3:0]   rot_i,
    output logic [N-1:0] res_o,
    output logic         c_o
);

    localparam int SW = $clog2(N);
    localparam logic [7:0] AMT_N = 8'(N);

    logic [SW-1:0] s;
    logic [SW-1:0] lsl_idx;
    logic [SW-1:0] rsh_idx;
    logic [SW:0]   s_inv;
    logic [SW-1:0] rot2;
    logic [SW:0]   rot2_inv;
    logic [N-1:0]  imm_ext;
    logic [N-1:0]  imm_rot;

    // For power-of-two N, (0 - s) mod N is N - s: the last bit shifted out by LSL.
    assign s        = amt_i[SW-1:0];
    assign lsl_idx  = SW'(0) - s;
    assign rsh_idx  = s - SW'(1);
    assign s_inv    = (SW+1)'(N) - {1'b0, s};
    assign rot2     = SW'({rot_i, 1'b0});
    assign rot2_inv = (SW+1)'(N) - {1'b0, rot2};
    assign imm_ext  = {{(N-8){1'b0}}, imm8_i};
    assign imm_rot  = (imm_ext >> rot2) | (imm_ext << rot2_inv);

    always_comb begin
        res_o = rm_i;
        c_o   = c_i;
        if (imm_sel_i) begin
            res_o = imm_rot;
            c_o   = (rot_i == 4'd0) ? c_i : imm_rot[N-1];
        end else if (amt_i != 8'd0) begin
            case (sh_type_i)
                SH_LSL: begin
                    if (amt_i < AMT_N) begin
                        res_o = rm_i << s;
                        c_o   = rm_i[lsl_idx];
                    end else begin
                        res_o = '0;
                        c_o   = (amt_i == AMT_N) ? rm_i[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amt_i < AMT_N) begin
                        res_o = rm_i >> s;
                        c_o   = rm_i[rsh_idx];
                    end else begin
                        res_o = '0;
                        c_o   = (amt_i == AMT_N) ? rm_i[N-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amt_i < AMT_N) begin
                        res_o = $unsigned($signed(rm_i) >>> s);
                        c_o   = rm_i[rsh_idx];
                    end else begin
                        res_o = {N{rm_i[N-1]}};
                        c_o   = rm_i[N-1];
                    end
                end
                default: begin
                    // A rotate by a nonzero multiple of N leaves rm intact; carry is bit N-1.
                    res_o = (rm_i >> s) | (rm_i << s_inv);
                    c_o   = res_o[N-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: builds operand 2 and shifter carry, registers them for the ALU.
// Define ALU_OPERAND_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus,
    output occ_e                state_o
);

    occ_e         state_q, state_d;
    logic [3:0]   opc_q;
    logic [N-1:0] op1_q;
    logic [N-1:0] op2_q;
    logic         c_q;
    logic [N-1:0] sh_res;
    logic         sh_c;
    logic         in_ready;
    logic         accept;
    logic         consume;
    logic         ld_new;

    barrel_shifter #(.N(N)) u_shifter (
        .rm_i      (bus.in_rm),
        .amt_i     (bus.in_sh_amt),
        .sh_type_i (bus.in_sh_type),
        .c_i       (bus.c_flag),
        .imm_sel_i (bus.in_imm_sel),
        .imm8_i    (bus.in_imm8),
        .rot_i     (bus.in_rot),
        .res_o     (sh_res),
        .c_o       (sh_c)
    );

`ifdef ALU_OPERAND_SKID_EN
    logic [3:0]   skid_opc_q;
    logic [N-1:0] skid_op1_q;
    logic [N-1:0] skid_op2_q;
    logic         skid_c_q;
    logic         ld_skid;
    logic         ld_from_skid;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = !rst && (state_q != ST_SKID);
`else
    assign in_ready = !rst && ((state_q == ST_EMPTY) || bus.out_ready);
`endif

    assign accept  = bus.in_valid && in_ready;
    assign consume = (state_q != ST_EMPTY) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        ld_new  = 1'b0;
`ifdef ALU_OPERAND_SKID_EN
        ld_skid      = 1'b0;
        ld_from_skid = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    ld_new  = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
`ifdef ALU_OPERAND_SKID_EN
                if (accept && !consume) begin
                    ld_skid = 1'b1;
                    state_d = ST_SKID;
                end else
`endif
                if (accept) begin
                    ld_new = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef ALU_OPERAND_SKID_EN
            ST_SKID: begin
                if (consume) begin
                    ld_from_skid = 1'b1;
                    state_d      = ST_OUT;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_new) begin
                opc_q <= bus.in_opc;
                op1_q <= bus.in_op1;
                op2_q <= sh_res;
                c_q   <= sh_c;
            end
`ifdef ALU_OPERAND_SKID_EN
            else if (ld_from_skid) begin
                opc_q <= skid_opc_q;
                op1_q <= skid_op1_q;
                op2_q <= skid_op2_q;
                c_q   <= skid_c_q;
            end
`endif
        end
    end

`ifdef ALU_OPERAND_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_opc_q <= '0;
            skid_op1_q <= '0;
            skid_op2_q <= '0;
            skid_c_q   <= 1'b0;
        end else if (ld_skid) begin
            skid_opc_q <= bus.in_opc;
            skid_op1_q <= bus.in_op1;
            skid_op2_q <= sh_res;
            skid_c_q   <= sh_c;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.opc       = opc_q;
    assign bus.op1       = op1_q;
    assign bus.op2       = op2_q;
    assign bus.c_shifter = c_q;
    assign state_o       = state_q;

endmodule
